iterative_multiplier: RTL and testbench

- Multi-cycle 64-bit shift-add multiplier downstream of the register file. Operands come from BusA/BusB.
- Produces the LEGv8 MUL, SMULH and UMULH results, plus a destination tag, for the writeback mux that drives BusW.
- Fills the gap left by the single-cycle ALU, which has no multiply.
- Control holds the pipeline while Busy is high and writes back on Done.

---
 rtl/iterative_multiplier_if.sv | 25 ++
 rtl/iterative_multiplier.sv | 130 +++++++++++++
 tb/tb_iterative_multiplier.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/iterative_multiplier_if.sv
// Operand/result bundle between the register-file read ports, the
// multiplier and the writeback mux.
interface iterative_multiplier_if #(
  parameter int WIDTH = 64
);
  logic             Start;
  logic [1:0]       MulOp;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [4:0]       DestIn;
  logic [WIDTH-1:0] Result;
  logic [4:0]       DestOut;
  logic             Busy;
  logic             Done;

  modport master (
    output Start, MulOp, A, B, DestIn,
    input  Result, DestOut, Busy, Done
  );

  modport slave (
    input  Start, MulOp, A, B, DestIn,
    output Result, DestOut, Busy, Done
  );
endinterface

// File: rtl/iterative_multiplier.sv
// Multi-cycle shift-add multiplier producing the LEGv8 MUL / SMULH / UMULH
// results with a destination tag for writeback on Done.
module iterative_multiplier #(
  parameter int WIDTH = 64
) (
  input logic                    Clk,
  input logic                    Reset,
  iterative_multiplier_if.slave  mulBus
);
  localparam int CW   = $clog2(WIDTH) + 1;
  localparam int IDXW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } mulStateT;

  mulStateT           stateR;
  mulStateT           nextStateS;
  logic [WIDTH-1:0]   aR;
  logic [WIDTH-1:0]   bR;
  logic [1:0]         opR;
  logic [4:0]         destR;
  logic [2*WIDTH-1:0] accR;
  logic [CW-1:0]      countR;
  logic [WIDTH-1:0]   resultR;
  logic [4:0]         destOutR;
  logic [WIDTH:0]     stepSumS;
  logic [WIDTH-1:0]   smulhS;
  logic [WIDTH-1:0]   resultSelS;
  logic               stepDoneS;

  // RUN keeps one terminal cycle once count reaches WIDTH, so the counter needs the extra bit.
  assign stepDoneS = (countR == CW'(WIDTH));

  // FSM state register
  always_ff @(posedge Clk) begin
    if (Reset) begin
      stateR <= IDLE;
    end else begin
      stateR <= nextStateS;
    end
  end

  // FSM next-state decode
  always_comb begin
    nextStateS = stateR;
    case (stateR)
      IDLE: begin
        if (mulBus.Start) begin
          nextStateS = RUN;
        end else begin
          nextStateS = IDLE;
        end
      end
      RUN: begin
        if (stepDoneS) begin
          nextStateS = FIX;
        end else begin
          nextStateS = RUN;
        end
      end
      FIX:     nextStateS = DONE;
      DONE:    nextStateS = IDLE;
      default: nextStateS = IDLE;
    endcase
  end

  // Shift-add step and result-half selection
  always_comb begin
    stepSumS   = {1'b0, accR[2*WIDTH-1:WIDTH]} +
                 (bR[countR[IDXW-1:0]] ? {1'b0, aR} : {(WIDTH+1){1'b0}});
    // Signed high half recovered from the unsigned high half.
    smulhS     = accR[2*WIDTH-1:WIDTH]
                 - (aR[WIDTH-1] ? bR : {WIDTH{1'b0}})
                 - (bR[WIDTH-1] ? aR : {WIDTH{1'b0}});
    resultSelS = accR[WIDTH-1:0];
    case (opR)
      2'b01:   resultSelS = smulhS;
      2'b10:   resultSelS = accR[2*WIDTH-1:WIDTH];
      default: resultSelS = accR[WIDTH-1:0];
    endcase
  end

  // Operand capture, right-shifting accumulator and output registers
  always_ff @(posedge Clk) begin
    if (Reset) begin
      aR       <= {WIDTH{1'b0}};
      bR       <= {WIDTH{1'b0}};
      opR      <= 2'b00;
      destR    <= 5'd0;
      accR     <= {(2*WIDTH){1'b0}};
      countR   <= {CW{1'b0}};
      resultR  <= {WIDTH{1'b0}};
      destOutR <= 5'd0;
    end else begin
      case (stateR)
        IDLE: begin
          if (mulBus.Start) begin
            aR     <= mulBus.A;
            bR     <= mulBus.B;
            opR    <= mulBus.MulOp;
            destR  <= mulBus.DestIn;
            accR   <= {(2*WIDTH){1'b0}};
            countR <= {CW{1'b0}};
          end
        end
        RUN: begin
          if (!stepDoneS) begin
            accR   <= {stepSumS, accR[WIDTH-1:1]};
            countR <= countR + CW'(1);
          end
        end
        FIX: begin
          resultR  <= resultSelS;
          destOutR <= destR;
        end
        default: begin
        end
      endcase
    end
  end

  assign mulBus.Result  = resultR;
  assign mulBus.DestOut = destOutR;
  assign mulBus.Busy    = (stateR != IDLE);
  assign mulBus.Done    = (stateR == DONE);
endmodule

// File: tb/tb_iterative_multiplier.sv
// Directed self-checking bench for iterative_multiplier (WIDTH=64).
module tb_iterative_multiplier;
  logic Clk;
  logic Reset;
  int   checks;
  int   failures;

  iterative_multiplier_if #(.WIDTH(64)) mulIf ();

  iterative_multiplier #(.WIDTH(64)) dut (
    .Clk    (Clk),
    .Reset  (Reset),
    .mulBus (mulIf)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic checkValue(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s: got 0x%016h expected 0x%016h", tag, actual, expected);
    end
  endtask

  // Present a request for one edge; returns at the negedge just after the accept edge.
  task automatic issue(input logic [1:0] op, input logic [63:0] a, input logic [63:0] b, input logic [4:0] dest);
    @(negedge Clk);
    mulIf.Start  = 1'b1;
    mulIf.MulOp  = op;
    mulIf.A      = a;
    mulIf.B      = b;
    mulIf.DestIn = dest;
    @(negedge Clk);
    mulIf.Start  = 1'b0;
    mulIf.A      = 64'h0;
    mulIf.B      = 64'h0;
    mulIf.DestIn = 5'd0;
  endtask

  task automatic waitDone(input int limit, output int cycles);
    bit seen;
    seen   = 1'b0;
    cycles = 0;
    while (!seen && cycles < limit) begin
      @(negedge Clk);
      cycles++;
      if (mulIf.Done === 1'b1) seen = 1'b1;
    end
  endtask

  task automatic runOp(input string tag, input logic [1:0] op, input logic [63:0] a, input logic [63:0] b,
                       input logic [4:0] dest, input logic [63:0] expRes);
    int cyc;
    issue(op, a, b, dest);
    checkValue({tag, " busy"}, {63'd0, mulIf.Busy}, 64'd1);
    waitDone(200, cyc);
    checkValue({tag, " latency"}, 64'(cyc), 64'd66);
    checkValue({tag, " result"}, mulIf.Result, expRes);
    checkValue({tag, " dest"}, {59'd0, mulIf.DestOut}, {59'd0, dest});
    @(negedge Clk);
    checkValue({tag, " busy_after"}, {63'd0, mulIf.Busy}, 64'd0);
    checkValue({tag, " done_after"}, {63'd0, mulIf.Done}, 64'd0);
    checkValue({tag, " result_hold"}, mulIf.Result, expRes);
  endtask

  logic [63:0] va [3];
  logic [63:0] vb [3];
  logic [63:0] ve [3];

  initial begin
    int cyc;
    int doneCount;
    int doneAt;

    checks       = 0;
    failures     = 0;
    Reset        = 1'b1;
    mulIf.Start  = 1'b0;
    mulIf.MulOp  = 2'b00;
    mulIf.A      = 64'h0;
    mulIf.B      = 64'h0;
    mulIf.DestIn = 5'd0;
    repeat (3) @(negedge Clk);
    Reset = 1'b0;
    checkValue("reset busy", {63'd0, mulIf.Busy}, 64'd0);
    checkValue("reset done", {63'd0, mulIf.Done}, 64'd0);
    checkValue("reset result", mulIf.Result, 64'h0);
    checkValue("reset dest", {59'd0, mulIf.DestOut}, 64'd0);

    runOp("mul3x5", 2'b00, 64'd3, 64'd5, 5'd7, 64'h0000_0000_0000_000F);
    runOp("umulh_ones", 2'b10, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 5'd4, 64'h0000_0000_0000_0001);
    runOp("mul_ones", 2'b00, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 5'd5, 64'hFFFF_FFFF_FFFF_FFFE);
    runOp("smulh_m1x2", 2'b01, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 5'd6, 64'hFFFF_FFFF_FFFF_FFFF);
    runOp("smulh_min", 2'b01, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 5'd8, 64'h4000_0000_0000_0000);
    runOp("smulh_max", 2'b01, 64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF, 5'd9, 64'h3FFF_FFFF_FFFF_FFFF);
    runOp("op11_x31", 2'b11, 64'h0000_0001_2345_6789, 64'h10, 5'd31, 64'h0000_0012_3456_7890);

    // A second Start mid-run must be dropped, not queued.
    issue(2'b00, 64'd100, 64'd200, 5'd3);
    doneCount = 0;
    doneAt    = 0;
    for (int c = 1; c <= 80; c++) begin
      @(negedge Clk);
      if (c == 10) begin
        mulIf.Start  = 1'b1;
        mulIf.A      = 64'd9;
        mulIf.B      = 64'd9;
        mulIf.DestIn = 5'd9;
      end else if (c == 11) begin
        mulIf.Start = 1'b0;
      end
      if (mulIf.Done === 1'b1) begin
        doneCount++;
        doneAt = c;
      end
    end
    checkValue("ignore done_count", 64'(doneCount), 64'd1);
    checkValue("ignore done_at", 64'(doneAt), 64'd66);
    checkValue("ignore result", mulIf.Result, 64'h0000_0000_0000_4E20);
    checkValue("ignore dest", {59'd0, mulIf.DestOut}, 64'd3);
    runOp("mul9x9", 2'b00, 64'd9, 64'd9, 5'd9, 64'd81);

    // Reset in the middle of a run abandons it.
    issue(2'b00, 64'd11, 64'd13, 5'd5);
    repeat (30) @(negedge Clk);
    Reset = 1'b1;
    @(negedge Clk);
    checkValue("midreset busy", {63'd0, mulIf.Busy}, 64'd0);
    checkValue("midreset done", {63'd0, mulIf.Done}, 64'd0);
    checkValue("midreset result", mulIf.Result, 64'h0);
    checkValue("midreset dest", {59'd0, mulIf.DestOut}, 64'd0);
    Reset     = 1'b0;
    doneCount = 0;
    for (int c = 0; c < 80; c++) begin
      @(negedge Clk);
      if (mulIf.Done === 1'b1) doneCount++;
    end
    checkValue("midreset no_done", 64'(doneCount), 64'd0);
    runOp("mul6x7", 2'b00, 64'd6, 64'd7, 5'd1, 64'd42);

    // Start held high: SMULH back to back, operands swapped while in DONE.
    va[0] = 64'hFFFF_FFFF_FFFF_FFFD; vb[0] = 64'd5; ve[0] = 64'hFFFF_FFFF_FFFF_FFFF;
    va[1] = 64'h4000_0000_0000_0000; vb[1] = 64'd4; ve[1] = 64'h0000_0000_0000_0001;
    va[2] = 64'hC000_0000_0000_0000; vb[2] = 64'd8; ve[2] = 64'hFFFF_FFFF_FFFF_FFFE;
    @(negedge Clk);
    mulIf.Start  = 1'b1;
    mulIf.MulOp  = 2'b01;
    mulIf.A      = va[0];
    mulIf.B      = vb[0];
    mulIf.DestIn = 5'd12;
    for (int i = 0; i < 3; i++) begin
      bit seen;
      seen = 1'b0;
      cyc  = 0;
      while (!seen && cyc < 200) begin
        @(negedge Clk);
        cyc++;
        if (i > 0 && cyc == 30) checkValue($sformatf("b2b hold%0d", i), mulIf.Result, ve[i-1]);
        if (mulIf.Done === 1'b1) seen = 1'b1;
      end
      checkValue($sformatf("b2b interval%0d", i), 64'(cyc), (i == 0) ? 64'd67 : 64'd68);
      checkValue($sformatf("b2b result%0d", i), mulIf.Result, ve[i]);
      checkValue($sformatf("b2b dest%0d", i), {59'd0, mulIf.DestOut}, 64'd12);
      if (i < 2) begin
        mulIf.A = va[i+1];
        mulIf.B = vb[i+1];
      end else begin
        mulIf.Start = 1'b0;
      end
    end
    repeat (2) @(negedge Clk);
    checkValue("b2b idle", {63'd0, mulIf.Busy}, 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
